// File: rtl/pmem_arbiter_rr.sv
// Arbiter between NUM_CLIENTS cache-side requesters and one cacheline adaptor.
// The winning request is latched for the whole transaction; the response is steered back to its owner.
module pmem_arbiter_rr #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter int PRIO_MODE   = 0,
  localparam int OW         = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLIENTS-1:0]        cl_read,
  input  logic [NUM_CLIENTS-1:0]        cl_write,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*LINE_W-1:0] cl_wdata,
  output logic [NUM_CLIENTS-1:0]        cl_resp,
  output logic [NUM_CLIENTS*LINE_W-1:0] cl_rdata,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [LINE_W-1:0]             mem_wdata,
  input  logic                          mem_resp,
  input  logic [LINE_W-1:0]             mem_rdata,
  output logic [OW-1:0]                 owner,
  output logic                          busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [NUM_CLIENTS-1:0]   req;
  logic                     grant;
  logic                     done;
  logic [OW-1:0]            ptr;
  logic [OW-1:0]            base;
  logic [OW-1:0]            win;
  logic [OW:0]              win_sum;
  logic [2*NUM_CLIENTS-1:0] req_shift;
  logic [NUM_CLIENTS-1:0]   req_rot;
  logic                     win_rd;
  logic                     win_wr;
  logic [ADDR_W-1:0]        win_addr;
  logic [LINE_W-1:0]        win_wdata;
  logic [OW-1:0]            owner_q;
  logic                     rd_q;
  logic                     wr_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [LINE_W-1:0]        wdata_q;

  assign req   = cl_read | cl_write;
  assign grant = (state == IDLE) && (|req);
  assign done  = (state == BUSY) && mem_resp;

  // Rotate requests so the search starts at bit 0, then map the hit back to a client index.
  assign base      = (PRIO_MODE != 0) ? '0 : ptr;
  assign req_shift = {req, req} >> base;
  assign req_rot   = req_shift[NUM_CLIENTS-1:0];

  always_comb begin
    win_sum = '0;
    for (int j = NUM_CLIENTS - 1; j >= 0; j--) begin
      if (req_rot[j]) win_sum = {1'b0, base} + (OW+1)'(j);
    end
    if (win_sum >= (OW+1)'(NUM_CLIENTS)) win_sum = win_sum - (OW+1)'(NUM_CLIENTS);
    win = win_sum[OW-1:0];
  end

  always_comb begin
    win_rd    = 1'b0;
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (win == OW'(i)) begin
        win_rd    = cl_read[i];
        win_wr    = cl_write[i];
        win_addr  = cl_addr[i*ADDR_W +: ADDR_W];
        win_wdata = cl_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|req) state_next = BUSY;
      BUSY:    if (mem_resp) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant latch: a simultaneous read+write is taken as a write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr     <= '0;
      owner_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner_q <= win;
      rd_q    <= win_rd & ~win_wr;
      wr_q    <= win_wr;
      addr_q  <= win_addr;
      wdata_q <= win_wdata;
    end else if (done) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      if (PRIO_MODE == 0)
        ptr <= (owner_q == OW'(NUM_CLIENTS - 1)) ? '0 : owner_q + OW'(1);
    end
  end

  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign owner     = owner_q;

  always_comb begin
    busy     = (state == BUSY);
    cl_resp  = '0;
    cl_rdata = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (done && owner_q == OW'(i)) begin
        cl_resp[i]                    = 1'b1;
        cl_rdata[i*LINE_W +: LINE_W] = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_pmem_arbiter_rr.sv
// Directed bench for pmem_arbiter_rr: a 2-client RR instance driven step by step,
// plus 3-client RR and fixed-priority instances served by an automatic adaptor.
module tb_pmem_arbiter_rr;
  localparam int AW = 32;
  localparam int LW = 256;

  typedef struct {
    int             client;
    logic [LW-1:0]  data;
  } resp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  // 2-client round-robin instance
  logic [1:0]      a_read, a_write, a_cl_resp;
  logic [2*AW-1:0] a_addr;
  logic [2*LW-1:0] a_wdata, a_cl_rdata;
  logic            a_mem_read, a_mem_write, a_mem_resp, a_busy;
  logic [AW-1:0]   a_mem_addr;
  logic [LW-1:0]   a_mem_wdata, a_mem_rdata;
  logic [0:0]      a_owner;

  // 3-client round-robin (b) and fixed-priority (c) instances
  logic [2:0]      b_read, c_read, bc_write, b_cl_resp, c_cl_resp;
  logic [3*AW-1:0] bc_addr;
  logic [3*LW-1:0] bc_wdata, b_cl_rdata, c_cl_rdata;
  logic            b_mem_read, b_mem_write, b_mem_resp, b_busy;
  logic            c_mem_read, c_mem_write, c_mem_resp, c_busy;
  logic [AW-1:0]   b_mem_addr, c_mem_addr;
  logic [LW-1:0]   b_mem_wdata, c_mem_wdata, bc_mem_rdata;
  logic [1:0]      b_owner, c_owner;

  pmem_arbiter_rr #(.NUM_CLIENTS(2), .ADDR_W(AW), .LINE_W(LW), .PRIO_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .cl_read(a_read), .cl_write(a_write), .cl_addr(a_addr),
    .cl_wdata(a_wdata), .cl_resp(a_cl_resp), .cl_rdata(a_cl_rdata), .mem_read(a_mem_read),
    .mem_write(a_mem_write), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_resp(a_mem_resp), .mem_rdata(a_mem_rdata), .owner(a_owner), .busy(a_busy));

  pmem_arbiter_rr #(.NUM_CLIENTS(3), .ADDR_W(AW), .LINE_W(LW), .PRIO_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .cl_read(b_read), .cl_write(bc_write), .cl_addr(bc_addr),
    .cl_wdata(bc_wdata), .cl_resp(b_cl_resp), .cl_rdata(b_cl_rdata), .mem_read(b_mem_read),
    .mem_write(b_mem_write), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_resp(b_mem_resp), .mem_rdata(bc_mem_rdata), .owner(b_owner), .busy(b_busy));

  pmem_arbiter_rr #(.NUM_CLIENTS(3), .ADDR_W(AW), .LINE_W(LW), .PRIO_MODE(1)) dut_c (
    .clk(clk), .rst(rst), .cl_read(c_read), .cl_write(bc_write), .cl_addr(bc_addr),
    .cl_wdata(bc_wdata), .cl_resp(c_cl_resp), .cl_rdata(c_cl_rdata), .mem_read(c_mem_read),
    .mem_write(c_mem_write), .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata),
    .mem_resp(c_mem_resp), .mem_rdata(bc_mem_rdata), .owner(c_owner), .busy(c_busy));

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: expected responses / grant owners, popped when the DUT produces them.
  resp_t exp_a[$];
  int    exp_b[$];
  int    exp_c[$];

  always @(negedge clk) begin
    resp_t e;
    if (a_cl_resp !== 2'b00) begin
      if (exp_a.size() == 0) begin
        chk("a_stray_resp", LW'(a_cl_resp), LW'(0));
      end else begin
        e = exp_a.pop_front();
        chk("a_resp_onehot", LW'(a_cl_resp), LW'(1) << e.client);
        chk("a_resp_data", a_cl_rdata[e.client*LW +: LW], e.data);
        chk("a_other_rdata", a_cl_rdata[(1-e.client)*LW +: LW], LW'(0));
      end
    end
  end

  int   b_grants = 0, b_idle = 0, c_grants = 0;
  logic b_busy_d = 1'b0, c_busy_d = 1'b0;

  always @(negedge clk) begin
    int eo;
    if (b_busy && !b_busy_d) begin
      if (b_grants > 0) chk("b_idle_gap", LW'(b_idle), LW'(1));
      if (exp_b.size() > 0) begin
        eo = exp_b.pop_front();
        chk("b_grant_order", LW'(b_owner), LW'(eo));
      end
      b_grants++;
    end
    if (!b_busy) b_idle++;
    else         b_idle = 0;
    b_busy_d = b_busy;
    if (c_busy && !c_busy_d) begin
      if (exp_c.size() > 0) begin
        eo = exp_c.pop_front();
        chk("c_grant_prio", LW'(c_owner), LW'(eo));
      end
      c_grants++;
    end
    c_busy_d = c_busy;
  end

  // Adaptor models for b and c: respond in the first busy cycle.
  initial begin
    b_mem_resp = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      b_mem_resp = b_busy && !b_mem_resp;
    end
  end

  initial begin
    c_mem_resp = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      c_mem_resp = c_busy && !c_mem_resp;
    end
  end

  initial begin
    int cyc;
    rst = 1'b0;
    a_read = '0; a_write = '0; a_addr = '0; a_wdata = '0; a_mem_resp = 1'b0; a_mem_rdata = '0;
    b_read = '0; c_read = '0; bc_write = '0; bc_addr = '0; bc_wdata = '0;
    bc_mem_rdata = {8{32'hB0B0_C0C0}};
    tick(); tick();
    chk("rst_busy", LW'(a_busy), LW'(0));
    chk("rst_mem_read", LW'(a_mem_read), LW'(0));
    chk("rst_mem_write", LW'(a_mem_write), LW'(0));
    chk("rst_mem_addr", LW'(a_mem_addr), LW'(0));
    chk("rst_mem_wdata", a_mem_wdata, LW'(0));
    chk("rst_cl_resp", LW'(a_cl_resp), LW'(0));
    chk("rst_owner", LW'(a_owner), LW'(0));
    rst = 1'b1;

    // Single read from client 1
    a_read = 2'b10;
    a_addr[AW +: AW] = 32'h0000_1040;
    tick();
    chk("rd_mem_read", LW'(a_mem_read), LW'(1));
    chk("rd_mem_write", LW'(a_mem_write), LW'(0));
    chk("rd_mem_addr", LW'(a_mem_addr), LW'(32'h1040));
    chk("rd_busy", LW'(a_busy), LW'(1));
    chk("rd_owner", LW'(a_owner), LW'(1));
    a_read = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_hold", LW'(a_mem_read), LW'(1));
    end
    a_mem_rdata = {32{8'hA5}};
    exp_a.push_back('{client: 1, data: {32{8'hA5}}});
    a_mem_resp = 1'b1;
    #1;
    chk("rd_cl_resp", LW'(a_cl_resp), LW'(2'b10));
    chk("rd_rdata1", a_cl_rdata[LW +: LW], {32{8'hA5}});
    chk("rd_rdata0_zero", a_cl_rdata[0 +: LW], LW'(0));
    tick();
    a_mem_resp = 1'b0;
    #1;
    chk("rd_done_busy", LW'(a_busy), LW'(0));
    chk("rd_done_mem_read", LW'(a_mem_read), LW'(0));
    chk("rd_done_cl_resp", LW'(a_cl_resp), LW'(0));

    // Write from client 0; client changes its inputs mid-transaction
    a_write = 2'b01;
    a_addr[0 +: AW] = 32'h0000_2000;
    a_wdata[0 +: LW] = {8{32'h1234_5678}};
    tick();
    chk("wr_mem_write", LW'(a_mem_write), LW'(1));
    chk("wr_mem_read", LW'(a_mem_read), LW'(0));
    chk("wr_owner", LW'(a_owner), LW'(0));
    a_write = 2'b00;
    a_addr[0 +: AW] = 32'hDEAD_0000;
    a_wdata[0 +: LW] = {8{32'hCAFE_F00D}};
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("wr_addr_hold", LW'(a_mem_addr), LW'(32'h2000));
      chk("wr_wdata_hold", a_mem_wdata, {8{32'h1234_5678}});
    end
    a_mem_rdata = LW'(32'h55);
    exp_a.push_back('{client: 0, data: LW'(32'h55)});
    a_mem_resp = 1'b1;
    #1;
    chk("wr_addr_at_resp", LW'(a_mem_addr), LW'(32'h2000));
    tick();
    a_mem_resp = 1'b0;
    chk("wr_done_mem_write", LW'(a_mem_write), LW'(0));

    // Read and write both set: write wins (ptr now 1, only client 0 requests)
    a_addr[0 +: AW] = 32'h0000_3000;
    a_read = 2'b01;
    a_write = 2'b01;
    tick();
    chk("rw_mem_write", LW'(a_mem_write), LW'(1));
    chk("rw_mem_read", LW'(a_mem_read), LW'(0));
    chk("rw_owner", LW'(a_owner), LW'(0));
    a_read = 2'b00;
    a_write = 2'b00;
    tick();
    a_mem_rdata = LW'(32'h77);
    exp_a.push_back('{client: 0, data: LW'(32'h77)});
    a_mem_resp = 1'b1;
    tick();
    a_mem_resp = 1'b0;

    // Reset in the middle of a transaction
    a_read = 2'b10;
    a_addr[AW +: AW] = 32'h0000_4000;
    tick();
    chk("mid_busy", LW'(a_busy), LW'(1));
    chk("mid_owner", LW'(a_owner), LW'(1));
    a_read = 2'b00;
    rst = 1'b0;
    tick();
    chk("mid_rst_busy", LW'(a_busy), LW'(0));
    chk("mid_rst_mem_read", LW'(a_mem_read), LW'(0));
    chk("mid_rst_owner", LW'(a_owner), LW'(0));
    chk("mid_rst_cl_resp", LW'(a_cl_resp), LW'(0));
    rst = 1'b1;
    a_mem_rdata = LW'(32'hEE);
    a_mem_resp = 1'b1;
    #1;
    chk("idle_stray_resp", LW'(a_cl_resp), LW'(0));
    tick();
    a_mem_resp = 1'b0;
    chk("idle_stray_busy", LW'(a_busy), LW'(0));

    // Both clients request: pointer was cleared by reset, so client 0 wins, then client 1
    a_read = 2'b11;
    tick();
    chk("ptr_after_rst", LW'(a_owner), LW'(0));
    a_read = 2'b10;
    a_mem_rdata = LW'(32'h99);
    exp_a.push_back('{client: 0, data: LW'(32'h99)});
    a_mem_resp = 1'b1;
    tick();
    a_mem_resp = 1'b0;
    tick();
    chk("rr_next_owner", LW'(a_owner), LW'(1));
    chk("rr_next_busy", LW'(a_busy), LW'(1));
    a_read = 2'b00;
    a_mem_rdata = LW'(32'h42);
    exp_a.push_back('{client: 1, data: LW'(32'h42)});
    a_mem_resp = 1'b1;
    tick();
    a_mem_resp = 1'b0;
    tick();

    // 3-client round-robin and fixed priority under continuous requests
    for (int i = 0; i < 2; i++) begin
      exp_b.push_back(0);
      exp_b.push_back(1);
      exp_b.push_back(2);
    end
    for (int i = 0; i < 5; i++) exp_c.push_back(0);
    b_read = 3'b111;
    c_read = 3'b101;
    cyc = 0;
    while ((b_grants < 6 || c_grants < 5) && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("bc_grant_timeout", LW'(cyc < 200), LW'(1));
    b_read = 3'b000;
    c_read = 3'b000;
    repeat (4) tick();

    chk("a_scoreboard_drained", LW'(exp_a.size()), LW'(0));
    chk("b_scoreboard_drained", LW'(exp_b.size()), LW'(0));
    chk("c_scoreboard_drained", LW'(exp_c.size()), LW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter_rr.md
# pmem_arbiter_rr

Parametrised arbiter between NUM_CLIENTS cache-side memory requesters and a single cacheline adaptor. It grants one client at a time, registers the winning request so the adaptor sees stable values for the whole transaction, and routes the response only to the owner. Clients are selected either round-robin, which is starvation-free, or by fixed priority. It sits between the L1 caches (I$, D$, and any prefetch buffer) and the physical-memory cacheline adaptor.

## Interface
- NUM_CLIENTS, 2: number of requesters, 2..8.
- ADDR_W, 32: address width.
- LINE_W, 256: cacheline width.
- PRIO_MODE, 0: 0 selects round-robin; 1 selects fixed priority, where client 0 is highest.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- cl_read  in  NUM_CLIENTS  per-client read request
- cl_write  in  NUM_CLIENTS  per-client write request
- cl_addr  in  NUM_CLIENTS*ADDR_W  per-client address; client i occupies slice [i*ADDR_W +: ADDR_W]
- cl_wdata  in  NUM_CLIENTS*LINE_W  per-client write line, sliced the same way
- cl_resp  out  NUM_CLIENTS  per-client completion pulse
- cl_rdata  out  NUM_CLIENTS*LINE_W  per-client read line
- mem_read  out  1  read to adaptor
- mem_write  out  1  write to adaptor
- mem_addr  out  ADDR_W  address to adaptor
- mem_wdata  out  LINE_W  write line to adaptor
- mem_resp  in  1  adaptor done
- mem_rdata  in  LINE_W  adaptor read line
- owner  out  $clog2(NUM_CLIENTS) (min 1)  index of current grantee; valid only while busy=1
- busy  out  1  transaction in flight

## Operation
- Client i requests when cl_read[i] | cl_write[i].
- States:
  - IDLE: no grant.
  - BUSY: a transaction is outstanding to the adaptor.
- IDLE with any request:
  - Choose winner w.
  - Latch owner=w, rd=cl_read[w], wr=cl_write[w], addr, wdata.
  - Go to BUSY.
- IDLE with no request: stay in IDLE.
- If cl_read[w] and cl_write[w] are both set at grant time, the write is taken and the read is dropped (rd=0, wr=1).
- BUSY:
  - mem_read=rd, mem_write=wr, mem_addr and mem_wdata come from the latched values.
  - Client-side changes during BUSY are ignored.
- BUSY with mem_resp=1:
  - cl_resp[owner]=1 and cl_rdata[owner]=mem_rdata in the same cycle, combinationally.
  - Next state is IDLE.
- BUSY with mem_resp=0: stay in BUSY.
- The mandatory IDLE cycle after a response lets the served client drop its request, so it is never re-granted stale.
- Round-robin (PRIO_MODE=0):
  - Pointer ptr holds the first index to consider.
  - Search runs ptr, ptr+1, … modulo NUM_CLIENTS; the first requester wins.
  - When mem_resp completes, ptr = (owner+1) mod NUM_CLIENTS.
- Fixed priority (PRIO_MODE=1): lowest requesting index wins; ptr is unused.
- Non-owner cl_resp=0 and cl_rdata slices=0 at all times. The owner's cl_rdata=0 when mem_resp=0.
- mem_resp seen in IDLE is ignored: no cl_resp, no state change.

## Timing
- Reset (rst=0 at posedge):
  - state=IDLE, ptr=0, owner=0, busy=0.
  - mem_read=mem_write=0, mem_addr=0, mem_wdata=0, all cl_resp=0.
- Reset mid-transaction abandons it with no cl_resp. The adaptor must also be reset.
- Grant latency: a request seen in IDLE at edge t drives mem_read/mem_write from cycle t+1. busy=1 from cycle t+1.
- mem_* are registered-source outputs and hold constant from grant until the cycle after mem_resp.
- Completion: cl_resp is a 1-cycle pulse coincident with mem_resp. busy drops the next cycle.
- Minimum transaction: 1 grant cycle + adaptor latency + 1 IDLE cycle. Back-to-back grants to different clients are separated by exactly one IDLE cycle.
- Fairness (RR): with all clients requesting continuously, each is served once per NUM_CLIENTS transactions.

## Test plan
- Reset then single read, client 1 addr=0x0000_1040, adaptor resp after 4 cycles with rdata=0xA5…A5:
  - mem_read=1 and mem_addr=0x1040 from the cycle after the request.
  - cl_resp[1] pulses once with that data.
  - cl_rdata[0]=0.
- RR, NUM_CLIENTS=3, all clients holding read requests:
  - Grant order is 0,1,2,0,1,2.
  - One IDLE cycle between grants.
- PRIO_MODE=1, clients 0 and 2 requesting continuously: client 0 is served every time and client 2 never.
- Client 0 changes addr and wdata mid-BUSY on a write of 0x2000 with line 0x1234…: mem_addr and mem_wdata keep their latched values until mem_resp.
- Both cl_read[0] and cl_write[0] set: mem_write=1 and mem_read=0.
- rst=0 asserted while BUSY:
  - Next cycle busy=0, mem_read=0, ptr=0, no cl_resp.
  - A stray mem_resp in IDLE produces no cl_resp.
